// File: rtl/sdram_cmd_arbiter.sv
// sdram_cmd_arbiter: SDR SDRAM command scheduler. It passes init through, owns auto-refresh, and runs
// single-burst ACT->RD/WR with auto-precharge. Define SDRAM_ARB_RR_EN for round-robin write/read arbitration.
module sdram_cmd_arbiter #(
  parameter int BA_W       = 2,
  parameter int ROW_W      = 13,
  parameter int COL_W      = 9,
  parameter int BL         = 4,
  parameter int CL         = 3,
  parameter int tRCD       = 2,
  parameter int tWR        = 2,
  parameter int tRP        = 2,
  parameter int tRFC       = 7,
  parameter int REF_PERIOD = 780
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic [3:0]                  init_command,
  input  logic [ROW_W-1:0]            init_saddr,
  input  logic                        init_done,
  input  logic                        wr_req,
  input  logic [BA_W+ROW_W+COL_W-1:0] wr_addr,
  output logic                        wr_ack,
  output logic                        wr_data_en,
  input  logic                        rd_req,
  input  logic [BA_W+ROW_W+COL_W-1:0] rd_addr,
  output logic                        rd_ack,
  output logic                        rd_data_valid,
  output logic [3:0]                  command,
  output logic [ROW_W-1:0]            saddr,
  output logic [BA_W-1:0]             sba,
  output logic                        ready
);

  localparam int AW    = BA_W + ROW_W + COL_W;
  localparam int REF_W = (REF_PERIOD > 1) ? $clog2(REF_PERIOD) : 1;

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_ACT  = 4'b0011;
  localparam logic [3:0] CMD_RD   = 4'b0101;
  localparam logic [3:0] CMD_WR   = 4'b0100;
  localparam logic [3:0] CMD_AREF = 4'b0001;

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_REF, S_ACT, S_WR, S_RD} state_t;

  state_t           state, state_nxt;
  logic [7:0]       cnt, cnt_nxt;
  logic             init_seen;
  logic [REF_W-1:0] ref_cnt;
  logic             ref_pend, ref_wrap, aref_issue;
  logic             lat_wr, lat_wr_nxt;
  logic [BA_W-1:0]  lat_ba, lat_ba_nxt;
  logic [COL_W-1:0] lat_col, lat_col_nxt;
  logic [3:0]       cmd_q, cmd_nxt;
  logic [ROW_W-1:0] saddr_q, saddr_nxt, col_addr;
  logic [BA_W-1:0]  sba_nxt;
  logic             wr_ack_nxt, rd_ack_nxt, wr_den_nxt, rd_val_nxt;
  logic             grant_wr;
  logic [AW-1:0]    req_addr;

`ifdef SDRAM_ARB_RR_EN
  // rd_pri flips on every grant so the other requester goes first next time.
  logic rd_pri;
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)          rd_pri <= 1'b0;
    else if (wr_ack_nxt) rd_pri <= 1'b1;
    else if (rd_ack_nxt) rd_pri <= 1'b0;
  end
  assign grant_wr = wr_req && !(rd_req && rd_pri);
`else
  assign grant_wr = wr_req;
`endif

  assign req_addr = grant_wr ? wr_addr : rd_addr;
  assign ref_wrap = init_seen && (ref_cnt == REF_W'(REF_PERIOD - 1));

  // Column phase address: A10 set selects auto-precharge.
  always_comb begin
    col_addr     = ROW_W'(lat_col);
    col_addr[10] = 1'b1;
  end

  // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    cmd_nxt     = CMD_NOP;
    saddr_nxt   = saddr_q;
    sba_nxt     = sba;
    lat_wr_nxt  = lat_wr;
    lat_ba_nxt  = lat_ba;
    lat_col_nxt = lat_col;
    wr_ack_nxt  = 1'b0;
    rd_ack_nxt  = 1'b0;
    aref_issue  = 1'b0;
    unique case (state)
      S_INIT: if (init_done) state_nxt = S_IDLE;
      S_IDLE: begin
        if (ref_pend) begin
          aref_issue = 1'b1;
          cmd_nxt    = CMD_AREF;
          cnt_nxt    = 8'(tRFC - 1);
          state_nxt  = S_REF;
        end else if (wr_req || rd_req) begin
          cmd_nxt     = CMD_ACT;
          cnt_nxt     = 8'(tRCD - 1);
          state_nxt   = S_ACT;
          lat_wr_nxt  = grant_wr;
          lat_ba_nxt  = req_addr[AW-1 -: BA_W];
          lat_col_nxt = req_addr[COL_W-1:0];
          saddr_nxt   = req_addr[COL_W +: ROW_W];
          sba_nxt     = req_addr[AW-1 -: BA_W];
          wr_ack_nxt  = grant_wr;
          rd_ack_nxt  = !grant_wr;
        end
      end
      S_ACT: begin
        if (cnt == '0) begin
          cmd_nxt   = lat_wr ? CMD_WR : CMD_RD;
          saddr_nxt = col_addr;
          sba_nxt   = lat_ba;
          state_nxt = lat_wr ? S_WR : S_RD;
          cnt_nxt   = lat_wr ? 8'(BL + tWR + tRP - 1) : 8'(CL + BL + tRP - 1);
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      S_REF, S_WR, S_RD: begin
        if (cnt == '0) state_nxt = S_IDLE;
        else           cnt_nxt   = cnt - 8'd1;
      end
      default: state_nxt = S_INIT;
    endcase
  end

  // Data strobes are decoded from the next-cycle countdown so they come out registered.
  assign wr_den_nxt = (state_nxt == S_WR) && (cnt_nxt >= 8'(tWR + tRP));
  assign rd_val_nxt = (state_nxt == S_RD) && (cnt_nxt >= 8'(tRP)) && (cnt_nxt < 8'(tRP + BL));

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state         <= S_INIT;
      cnt           <= '0;
      init_seen     <= 1'b0;
      ref_cnt       <= '0;
      ref_pend      <= 1'b0;
      lat_wr        <= 1'b0;
      lat_ba        <= '0;
      lat_col       <= '0;
      cmd_q         <= CMD_NOP;
      saddr_q       <= '0;
      sba           <= '0;
      wr_ack        <= 1'b0;
      rd_ack        <= 1'b0;
      wr_data_en    <= 1'b0;
      rd_data_valid <= 1'b0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      lat_wr        <= lat_wr_nxt;
      lat_ba        <= lat_ba_nxt;
      lat_col       <= lat_col_nxt;
      cmd_q         <= cmd_nxt;
      saddr_q       <= saddr_nxt;
      sba           <= sba_nxt;
      wr_ack        <= wr_ack_nxt;
      rd_ack        <= rd_ack_nxt;
      wr_data_en    <= wr_den_nxt;
      rd_data_valid <= rd_val_nxt;
      if (state == S_INIT && init_done) init_seen <= 1'b1;
      if (init_seen) ref_cnt <= ref_wrap ? '0 : ref_cnt + 1'b1;
      // A wrap while already pending saturates; a pending refresh is retired by its AREF.
      if (ref_wrap)        ref_pend <= 1'b1;
      else if (aref_issue) ref_pend <= 1'b0;
    end
  end

  assign command = (state == S_INIT) ? init_command : cmd_q;
  assign saddr   = (state == S_INIT) ? init_saddr   : saddr_q;
  assign ready   = init_seen && (state == S_IDLE);

endmodule

// File: tb/tb_sdram_cmd_arbiter.sv
// Directed bench for sdram_cmd_arbiter: init pass-through, refresh, write/read bursts, arbitration, reset.
module tb_sdram_cmd_arbiter;

  localparam logic [3:0] NOP  = 4'b0111;
  localparam logic [3:0] ACT  = 4'b0011;
  localparam logic [3:0] RD   = 4'b0101;
  localparam logic [3:0] WR   = 4'b0100;
  localparam logic [3:0] AREF = 4'b0001;
  localparam logic [3:0] PRE  = 4'b0010;
  localparam logic [3:0] MSET = 4'b0000;

  logic        CLK = 1'b0;
  logic        RST_N = 1'b0;
  logic [3:0]  init_command;
  logic [12:0] init_saddr;
  logic        init_done;
  logic        wr_req, rd_req;
  logic [23:0] wr_addr, rd_addr;
  logic        wr_ack, wr_data_en, rd_ack, rd_data_valid, ready;
  logic [3:0]  command;
  logic [12:0] saddr;
  logic [1:0]  sba;

  sdram_cmd_arbiter dut (
    .CLK(CLK), .RST_N(RST_N),
    .init_command(init_command), .init_saddr(init_saddr), .init_done(init_done),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_ack(wr_ack), .wr_data_en(wr_data_en),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data_valid(rd_data_valid),
    .command(command), .saddr(saddr), .sba(sba), .ready(ready)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [12:0] sa;
    logic [1:0]  ba;
    logic        wack, wden, rack, rval, rdy;
  } obs_t;

  typedef struct {
    logic [3:0]  icmd;
    logic [12:0] isa;
    logic        idone;
    logic [3:0]  ecmd;
    logic [12:0] esa;
    logic        erdy;
  } ivec_t;

  int    total = 0;
  int    bad   = 0;
  int    c     = 0;
  ivec_t iv[7];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
    c++;
  endtask

  task automatic check_obs(input string name, input obs_t want, input bit chk_addr);
    obs_t got, w;
    got = {command, saddr, sba, wr_ack, wr_data_en, rd_ack, rd_data_valid, ready};
    w   = want;
    if (!chk_addr) begin
      got.sa = '0; got.ba = '0; w.sa = '0; w.ba = '0;
    end
    check(name, 32'(got), 32'(w));
  endtask

  // Expected outputs at a given offset from the ACT cycle of one transaction.
  function automatic obs_t txn_exp(input bit wr, input int off, input logic [1:0] ba,
                                   input logic [12:0] row, input logic [8:0] col);
    obs_t e;
    e = '0;
    e.cmd = NOP;
    if (off == 0) begin
      e.cmd = ACT; e.sa = row; e.ba = ba;
      if (wr) e.wack = 1'b1; else e.rack = 1'b1;
    end
    if (off == 2) begin
      e.cmd = wr ? WR : RD; e.sa = 13'h400 | {4'b0, col}; e.ba = ba;
    end
    if (wr) begin
      e.wden = (off >= 2 && off <= 5);
      e.rdy  = (off == 10);
    end else begin
      e.rval = (off >= 5 && off <= 8);
      e.rdy  = (off == 11);
    end
    return e;
  endfunction

  // Starts in the ACT cycle, ends in the first ready cycle afterwards.
  task automatic follow_txn(input bit wr, input logic [1:0] ba, input logic [12:0] row,
                            input logic [8:0] col, input bit drop, input string tag);
    int last;
    last = wr ? 10 : 11;
    for (int off = 0; off <= last; off++) begin
      check_obs($sformatf("%s off%0d", tag, off), txn_exp(wr, off, ba, row, col), (off == 0 || off == 2));
      if (off == 0 && drop) begin
        wr_req = 1'b0;
        rd_req = 1'b0;
      end
      if (off < last) tick();
    end
  endtask

  initial begin
    int   quiet_bad;
    int   w;
    bit   kind, exp_kind;
    obs_t e;

    init_command = NOP; init_saddr = '0; init_done = 1'b0;
    wr_req = 1'b0; rd_req = 1'b0; wr_addr = '0; rd_addr = '0;

    iv[0] = '{NOP,  13'h000, 1'b0, NOP,  13'h000, 1'b0};
    iv[1] = '{PRE,  13'h400, 1'b0, PRE,  13'h400, 1'b0};
    iv[2] = '{AREF, 13'h000, 1'b0, AREF, 13'h000, 1'b0};
    iv[3] = '{MSET, 13'h032, 1'b1, MSET, 13'h032, 1'b0};
    iv[4] = '{ACT,  13'h123, 1'b0, NOP,  13'h000, 1'b1};
    iv[5] = '{PRE,  13'h1FF, 1'b1, NOP,  13'h000, 1'b1};
    iv[6] = '{MSET, 13'h032, 1'b0, NOP,  13'h000, 1'b1};

    // Reset state
    repeat (3) @(posedge CLK);
    #1;
    e = '0; e.cmd = NOP;
    check_obs("reset outputs", e, 1'b1);
    RST_N = 1'b1;

    // Init pass-through, then init inputs ignored
    for (int i = 0; i < 7; i++) begin
      init_command = iv[i].icmd; init_saddr = iv[i].isa; init_done = iv[i].idone;
      #1;
      check($sformatf("init v%0d command", i), 32'(command), 32'(iv[i].ecmd));
      check($sformatf("init v%0d saddr", i),   32'(saddr),   32'(iv[i].esa));
      check($sformatf("init v%0d ready", i),   32'(ready),   32'(iv[i].erdy));
      tick();
      if (i == 3) c = 0;
    end
    init_command = PRE; init_done = 1'b0;

    // Idle until refresh falls due
    quiet_bad = 0;
    while (c < 780) begin
      if (command !== NOP || ready !== 1'b1 || wr_ack !== 1'b0 || rd_ack !== 1'b0) quiet_bad++;
      tick();
    end
    check("idle quiet", 32'(quiet_bad), 0);
    check("due cycle ready", 32'(ready), 1);
    wr_req  = 1'b1;
    wr_addr = {2'd1, 13'h0A5, 9'h010};
    tick();
    check("aref cmd", 32'(command), 32'(AREF));
    check("aref ready", 32'(ready), 0);
    check("aref no ack", 32'(wr_ack), 0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      check($sformatf("aref nop%0d", k), 32'({command, wr_ack, ready}), 32'({NOP, 1'b0, 1'b0}));
    end
    tick();
    check("post aref idle", 32'({command, wr_ack, ready}), 32'({NOP, 1'b0, 1'b1}));
    tick();

    // Write burst granted after refresh
    follow_txn(1'b1, 2'd1, 13'h0A5, 9'h010, 1'b1, "wr");

    // Read burst to the same address
    rd_req  = 1'b1;
    rd_addr = {2'd1, 13'h0A5, 9'h010};
    tick();
    follow_txn(1'b0, 2'd1, 13'h0A5, 9'h010, 1'b1, "rd");

    // Both requests held
    wr_addr = {2'd2, 13'h1ABC, 9'h000};
    rd_addr = {2'd3, 13'h0777, 9'h1FF};
    wr_req = 1'b1; rd_req = 1'b1;
    for (int g = 0; g < 4; g++) begin
      w = 0;
      while (!(wr_ack || rd_ack) && w < 40) begin
        tick();
        w++;
      end
      check($sformatf("grant%0d seen", g), 32'(wr_ack || rd_ack), 1);
      if (wr_ack || rd_ack) begin
        kind = wr_ack;
`ifdef SDRAM_ARB_RR_EN
        exp_kind = (g % 2 == 0);
`else
        exp_kind = 1'b1;
`endif
        check($sformatf("grant%0d is_write", g), 32'(kind), 32'(exp_kind));
        if (kind) follow_txn(1'b1, 2'd2, 13'h1ABC, 9'h000, 1'b0, $sformatf("arb%0d", g));
        else      follow_txn(1'b0, 2'd3, 13'h0777, 9'h1FF, 1'b0, $sformatf("arb%0d", g));
      end
      if (g == 3) begin
        wr_req = 1'b0; rd_req = 1'b0;
      end
    end

    // Reset during write data
    init_command = NOP;
    wr_addr = {2'd1, 13'h0A5, 9'h010};
    wr_req  = 1'b1;
    tick();
    check("rst wr ack", 32'(wr_ack), 1);
    wr_req = 1'b0;
    repeat (3) tick();
    check("rst wr data_en before", 32'(wr_data_en), 1);
    RST_N = 1'b0;
    #1;
    check("rst mid cmd", 32'(command), 32'(NOP));
    check("rst mid data_en", 32'(wr_data_en), 0);
    check("rst mid ready", 32'(ready), 0);
    #2;
    RST_N = 1'b1;
    init_command = PRE;
    wr_req = 1'b1;
    #1;
    check("rst back in init", 32'(command), 32'(PRE));
    quiet_bad = 0;
    repeat (3) begin
      tick();
      if (wr_ack !== 1'b0 || ready !== 1'b0 || command !== PRE) quiet_bad++;
    end
    check("init ignores req", 32'(quiet_bad), 0);
    wr_req = 1'b0;
    init_command = NOP;
    init_done = 1'b1;
    tick();
    init_done = 1'b0;
    check("reinit ready", 32'(ready), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
